// File: rtl/modn_detector.sv
// Serial divisibility-by-N detector: flags when the accepted bit stream is a multiple of N.
// Optional LSB-first mode compiled in with `define MODN_LSB_FIRST_EN.
module modn_detector #(
    parameter int N  = 3,
    parameter int CW = 8,
    localparam int RW = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic          in,
`ifdef MODN_LSB_FIRST_EN
    input  logic          lsb_first,
`endif
    output logic          out,
    output logic          out_valid,
    output logic [RW-1:0] rem,
    output logic [CW-1:0] bit_count
);

    localparam logic [RW:0]   NV   = (RW+1)'(N);
    localparam logic [CW-1:0] CMAX = '1;

    logic [RW-1:0] rem_base;
    logic [RW-1:0] rem_next;
    logic [RW:0]   msb_sum;
    logic [RW:0]   msb_red;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_next;

`ifdef MODN_LSB_FIRST_EN
    logic [RW-1:0] weight;
    logic          lsb_mode;
    logic [RW-1:0] w_base;
    logic [RW-1:0] w_next;
    logic          mode;
    logic [RW:0]   lsb_sum;
    logic [RW:0]   lsb_red;
    logic [RW:0]   w_dbl;
    logic [RW:0]   w_red;
`endif

    // Both operands of each sum are < N, so a single conditional subtract reduces mod N.
    always_comb begin
        rem_base = clear ? '0 : rem;
        msb_sum  = {rem_base, in};
        msb_red  = (msb_sum >= NV) ? msb_sum - NV : msb_sum;
        cnt_base = clear ? '0 : bit_count;
        cnt_next = (cnt_base == CMAX) ? cnt_base : cnt_base + 1'b1;
`ifdef MODN_LSB_FIRST_EN
        w_base   = clear ? RW'(1) : weight;
        mode     = clear ? lsb_first : lsb_mode;
        lsb_sum  = {1'b0, rem_base} + (in ? {1'b0, w_base} : '0);
        lsb_red  = (lsb_sum >= NV) ? lsb_sum - NV : lsb_sum;
        w_dbl    = {w_base, 1'b0};
        w_red    = (w_dbl >= NV) ? w_dbl - NV : w_dbl;
        w_next   = w_red[RW-1:0];
        rem_next = mode ? lsb_red[RW-1:0] : msb_red[RW-1:0];
`else
        rem_next = msb_red[RW-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            bit_count <= '0;
`ifdef MODN_LSB_FIRST_EN
            weight    <= RW'(1);
            lsb_mode  <= 1'b0;
`endif
        end else if (in_valid) begin
            rem       <= rem_next;
            out       <= (rem_next == '0);
            out_valid <= 1'b1;
            bit_count <= cnt_next;
`ifdef MODN_LSB_FIRST_EN
            weight    <= w_next;
            lsb_mode  <= mode;
`endif
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                rem       <= '0;
                out       <= 1'b0;
                bit_count <= '0;
`ifdef MODN_LSB_FIRST_EN
                weight    <= RW'(1);
                lsb_mode  <= lsb_first;
`endif
            end
        end
    end

endmodule

// File: tb/tb_modn_detector.sv
// Testbench for modn_detector: three instances (N=3/5/7) share one stimulus stream,
// directed scenarios against fixed expectations and random traffic against a bit-queue model.
module tb_modn_detector;

    localparam int NS [3] = '{3, 5, 7};
    localparam int CWS[3] = '{8, 8, 2};

    logic clk = 1'b0;
    logic reset, clear, in_valid, in;

    logic       out0, out1, out2;
    logic       ov0, ov1, ov2;
    logic [1:0] rem0;
    logic [2:0] rem1, rem2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int orem[3], ocnt[3];
    logic oout[3], oov[3];

    int vectors = 0;
    int errors  = 0;

    bit q[$];
    bit started;
    bit ovexp;

    always #5 clk = ~clk;

    modn_detector #(.N(3), .CW(8)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out0), .out_valid(ov0), .rem(rem0), .bit_count(cnt0)
    );
    modn_detector #(.N(5), .CW(8)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out1), .out_valid(ov1), .rem(rem1), .bit_count(cnt1)
    );
    modn_detector #(.N(7), .CW(2)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out2), .out_valid(ov2), .rem(rem2), .bit_count(cnt2)
    );

    always_comb begin
        orem[0] = int'(rem0); orem[1] = int'(rem1); orem[2] = int'(rem2);
        ocnt[0] = int'(cnt0); ocnt[1] = int'(cnt1); ocnt[2] = int'(cnt2);
        oout[0] = out0; oout[1] = out1; oout[2] = out2;
        oov[0]  = ov0;  oov[1]  = ov1;  oov[2]  = ov2;
    end

    // Value of the whole accepted stream modulo n, evaluated from the stored bits.
    function automatic int exp_rem(input int n);
        int r = 0;
        foreach (q[i]) r = (r * 2 + int'(q[i])) % n;
        return r;
    endfunction

    function automatic int exp_cnt(input int cw);
        int mx = (1 << cw) - 1;
        return (q.size() > mx) ? mx : q.size();
    endfunction

    task automatic step(input logic c, input logic v, input logic b);
        @(negedge clk);
        clear = c; in_valid = v; in = b;
        @(posedge clk);
        #1;
        if (v) begin
            if (c) q.delete();
            q.push_back(b);
            started = 1'b1;
        end else if (c) begin
            q.delete();
            started = 1'b0;
        end
        ovexp = v;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in = 1'b0;
        q.delete(); started = 1'b0; ovexp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (orem[k] !== 0 || oout[k] !== 1'b0 || oov[k] !== 1'b0 || ocnt[k] !== 0) begin
                errors++;
                $display("FAIL reset dut%0d: rem=%0d out=%b ov=%b cnt=%0d, want all 0",
                         k, orem[k], oout[k], oov[k], ocnt[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_msb_basic;
        int er[3] = '{1, 0, 0};
        bit eo[3] = '{0, 1, 1};
        bit bits[3] = '{1, 1, 0};
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, bits[i]);
            vectors++;
            if (orem[0] !== er[i] || oout[0] !== eo[i] || oov[0] !== 1'b1 || ocnt[0] !== i + 1) begin
                errors++;
                $display("FAIL msb_basic bit%0d: rem=%0d out=%b ov=%b cnt=%0d, want %0d %b 1 %0d",
                         i, orem[0], oout[0], oov[0], ocnt[0], er[i], eo[i], i + 1);
            end
        end
    endtask

    task automatic test_gaps;
        int er[4] = '{1, 2, 0, 0};
        bit eo[4] = '{0, 0, 1, 1};
        bit bits[4] = '{1, 0, 1, 0};
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, bits[i]);
            vectors++;
            if (orem[1] !== er[i] || oout[1] !== eo[i] || oov[1] !== 1'b1) begin
                errors++;
                $display("FAIL gaps accept%0d: rem=%0d out=%b ov=%b, want %0d %b 1",
                         i, orem[1], oout[1], oov[1], er[i], eo[i]);
            end
            repeat (2) begin
                step(1'b0, 1'b0, ~bits[i]);
                vectors++;
                if (orem[1] !== er[i] || oout[1] !== eo[i] || oov[1] !== 1'b0 || ocnt[1] !== i + 1) begin
                    errors++;
                    $display("FAIL gaps hold%0d: rem=%0d out=%b ov=%b cnt=%0d, want %0d %b 0 %0d",
                             i, orem[1], oout[1], oov[1], ocnt[1], er[i], eo[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_clear;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (orem[0] !== 2) begin
            errors++;
            $display("FAIL clear_pre: rem=%0d, want 2", orem[0]);
        end
        step(1'b1, 1'b1, 1'b1);
        vectors++;
        if (orem[0] !== 1 || oout[0] !== 1'b0 || oov[0] !== 1'b1 || ocnt[0] !== 1) begin
            errors++;
            $display("FAIL clear_with_bit: rem=%0d out=%b ov=%b cnt=%0d, want 1 0 1 1",
                     orem[0], oout[0], oov[0], ocnt[0]);
        end
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if (orem[0] !== 0 || oout[0] !== 1'b1 || ocnt[0] !== 1) begin
            errors++;
            $display("FAIL clear_with_zero: rem=%0d out=%b cnt=%0d, want 0 1 1",
                     orem[0], oout[0], ocnt[0]);
        end
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (orem[0] !== 0 || oout[0] !== 1'b0 || oov[0] !== 1'b0 || ocnt[0] !== 0) begin
            errors++;
            $display("FAIL clear_alone: rem=%0d out=%b ov=%b cnt=%0d, want 0 0 0 0",
                     orem[0], oout[0], oov[0], ocnt[0]);
        end
    endtask

    task automatic test_async_reset;
        bit eo[3] = '{0, 0, 1};
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (orem[k] !== 0 || oout[k] !== 1'b0 || oov[k] !== 1'b0 || ocnt[k] !== 0) begin
                errors++;
                $display("FAIL async_reset dut%0d: rem=%0d out=%b ov=%b cnt=%0d, want all 0",
                         k, orem[k], oout[k], oov[k], ocnt[k]);
            end
        end
        q.delete(); started = 1'b0; ovexp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            vectors++;
            if (oout[2] !== eo[i] || oov[2] !== 1'b1) begin
                errors++;
                $display("FAIL after_reset bit%0d: out=%b ov=%b, want %b 1",
                         i, oout[2], oov[2], eo[i]);
            end
        end
    endtask

    task automatic test_saturate;
        int ec[6] = '{1, 2, 3, 3, 3, 3};
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'(i));
            vectors++;
            if (ocnt[2] !== ec[i] || ocnt[0] !== i + 1) begin
                errors++;
                $display("FAIL saturate bit%0d: cnt_cw2=%0d cnt_cw8=%0d, want %0d %0d",
                         i, ocnt[2], ocnt[0], ec[i], i + 1);
            end
        end
    endtask

    task automatic test_random;
        bit c, v, b;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom);
            step(c, v, b);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (orem[k] !== exp_rem(NS[k]) ||
                    oout[k] !== (started && exp_rem(NS[k]) == 0) ||
                    oov[k] !== ovexp ||
                    ocnt[k] !== exp_cnt(CWS[k])) begin
                    errors++;
                    $display("FAIL random i%0d dut%0d: rem=%0d out=%b ov=%b cnt=%0d, want %0d %b %b %0d",
                             i, k, orem[k], oout[k], oov[k], ocnt[k], exp_rem(NS[k]),
                             started && exp_rem(NS[k]) == 0, ovexp, exp_cnt(CWS[k]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_gaps();
        test_clear();
        test_async_reset();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
